regfile_dump_reader: RTL and testbench

Sequential read-side client of the pipeline register file. On a start pulse it walks every architectural register in pairs through the register file's two asynchronous read ports. It captures each pair into a snapshot buffer and streams the values out one word per beat on a valid/ready interface. The block sits beside the ID stage, sharing the register file read ports through the debug/testbench mux. It is used for end-of-program register dumps and for checking results against the golden model.

---
 rtl/regfile_dump_reader.sv | 169 ++++++++++++++++
 tb/tb_regfile_dump_reader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
//   On a start pulse, reads every architectural register in pairs through the
//   register file's two asynchronous read ports. Each pair is snapshotted into
//   bufA/bufB in a single FETCH cycle. The snapshot is then streamed out one
//   word per beat on a valid/ready interface.
//
//   Optional feature (macro REGDUMP_CHECKSUM_EN): an XOR checksum of all dumped
//   words is appended as one extra beat (outIndex=0, outLast=1).
//
// Parameters
//   SIZE      number of registers dumped; even, 2..32
// Ports
//   clk       system clock, all state on posedge
//   rst       synchronous active-high reset
//   start     begin a dump (only honoured while idle)
//   busy      high whenever not idle
//   done      one-cycle pulse after the final beat is accepted
//   rdAddr1/2 register file read addresses (ptr, ptr+1)
//   rdData1/2 register file read data (combinational in rdAddr)
//   outValid/outReady/outData/outIndex/outLast  output stream
module regfile_dump_reader #(
    parameter int SIZE = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  rdAddr1,
    output logic [4:0]  rdAddr2,
    input  logic [31:0] rdData1,
    input  logic [31:0] rdData2,
    output logic        outValid,
    input  logic        outReady,
    output logic [31:0] outData,
    output logic [4:0]  outIndex,
    output logic        outLast
);

    generate
        if ((SIZE < 2) || (SIZE > 32) || ((SIZE % 2) != 0)) begin : g_bad_size
            $error("regfile_dump_reader: SIZE=%0d must be even and in 2..32", SIZE);
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_SEND_A = 3'd2,
        S_SEND_B = 3'd3,
`ifdef REGDUMP_CHECKSUM_EN
        S_CHK    = 3'd4,
`endif
        S_DONE   = 3'd5
    } state_t;

    // 6-bit compare so SIZE=32 is representable next to the 5-bit pointer.
    localparam logic [5:0] SIZE6 = 6'(SIZE);

    state_t      state, state_nx;
    logic [4:0]  ptr;
    logic [31:0] bufA, bufB;
    logic        last_pair;

`ifdef REGDUMP_CHECKSUM_EN
    logic [31:0] acc;
`endif

    assign last_pair = (({1'b0, ptr} + 6'd2) == SIZE6);

    // Read addresses follow the pointer unconditionally; the external mux
    // decides whether the register file actually sees them (busy=1).
    assign rdAddr1 = ptr;
    assign rdAddr2 = ptr + 5'd1;

    // Next state and outputs. Stream outputs are decoded from state and the
    // snapshot registers, so they are naturally stable during backpressure.
    always_comb begin
        state_nx = state;
        busy     = (state != S_IDLE);
        done     = 1'b0;
        outValid = 1'b0;
        outData  = 32'd0;
        outIndex = 5'd0;
        outLast  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_FETCH;
            end
            S_FETCH: begin
                state_nx = S_SEND_A;
            end
            S_SEND_A: begin
                outValid = 1'b1;
                outData  = bufA;
                outIndex = ptr;
                if (outReady) state_nx = S_SEND_B;
            end
            S_SEND_B: begin
                outValid = 1'b1;
                outData  = bufB;
                outIndex = ptr + 5'd1;
`ifdef REGDUMP_CHECKSUM_EN
                if (outReady) state_nx = last_pair ? S_CHK : S_FETCH;
`else
                outLast  = last_pair;
                if (outReady) state_nx = last_pair ? S_DONE : S_FETCH;
`endif
            end
`ifdef REGDUMP_CHECKSUM_EN
            S_CHK: begin
                outValid = 1'b1;
                outData  = acc;
                outIndex = 5'd0;
                outLast  = 1'b1;
                if (outReady) state_nx = S_DONE;
            end
`endif
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            ptr   <= 5'd0;
            bufA  <= 32'd0;
            bufB  <= 32'd0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE, S_DONE: begin
                    ptr <= 5'd0;
                end
                S_FETCH: begin
                    // Snapshot point: later register file writes do not
                    // reach this pair's beats.
                    bufA <= rdData1;
                    bufB <= rdData2;
                end
                S_SEND_B: begin
                    // Pointer stays at the final pair; it is cleared in DONE.
                    if (outReady && !last_pair) ptr <= ptr + 5'd2;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef REGDUMP_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= 32'd0;
        end else if ((state == S_IDLE) && start) begin
            acc <= 32'd0;
        end else if (((state == S_SEND_A) || (state == S_SEND_B)) && outReady) begin
            acc <= acc ^ outData;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_dump_reader.sv
module tb_regfile_dump_reader;

`ifdef REGDUMP_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    localparam int NB = 32 + CK;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, outReady;
    logic        busy, done, outValid, outLast;
    logic [4:0]  rdAddr1, rdAddr2, outIndex;
    logic [31:0] rdData1, rdData2, outData;

    logic        start2, ready2;
    logic        busy2, done2, ov2, ol2;
    logic [4:0]  ra1_2, ra2_2, oi2;
    logic [31:0] rd1_2, rd2_2, od2;

    // Register file model: async read, negedge write, r0 hardwired to zero.
    logic [31:0] rf [32];
    logic        rf_rst, we;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    always @(negedge clk) begin
        if (rf_rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'd0 : 32'd2;
        end else if (we && (waddr != 5'd0)) begin
            rf[waddr] <= wdata;
        end
    end

    assign rdData1 = rf[rdAddr1];
    assign rdData2 = rf[rdAddr2];
    assign rd1_2   = rf[ra1_2];
    assign rd2_2   = rf[ra2_2];

    regfile_dump_reader #(.SIZE(32)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rdAddr1(rdAddr1), .rdAddr2(rdAddr2), .rdData1(rdData1), .rdData2(rdData2),
        .outValid(outValid), .outReady(outReady), .outData(outData),
        .outIndex(outIndex), .outLast(outLast)
    );

    regfile_dump_reader #(.SIZE(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .rdAddr1(ra1_2), .rdAddr2(ra2_2), .rdData1(rd1_2), .rdData2(rd2_2),
        .outValid(ov2), .outReady(ready2), .outData(od2),
        .outIndex(oi2), .outLast(ol2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_d [33];
    logic [4:0]  exp_i [33];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, want);
        end
    endtask

    task automatic exp_finish();
        logic [31:0] x;
        x = 32'd0;
        for (int i = 0; i < 32; i++) begin
            x = x ^ exp_d[i];
            exp_i[i] = 5'(i);
        end
        exp_d[32] = x;
        exp_i[32] = 5'd0;
    endtask

    task automatic exp_reset_rf();
        for (int i = 0; i < 32; i++) exp_d[i] = (i == 0) ? 32'd0 : 32'd2;
        exp_finish();
    endtask

    task automatic exp_mul3();
        for (int i = 0; i < 32; i++) exp_d[i] = 32'(i * 3);
        exp_finish();
    endtask

    // Called at posedge+1; leaves us at E0+1 (block in FETCH).
    task automatic kick(input bit hold);
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
    endtask

    // Consumes one dump starting at E0+1. wr_c: cycle at which a register
    // write is scheduled (negedge of that cycle). exp_last: expected edge
    // number of the final handshake, or -1 to skip that check.
    task automatic collect(input int nb, input bit toggle, input int wr_c,
                           input logic [4:0] wa, input logic [31:0] wd, input int exp_last);
        int c, b, last_hs;
        bit stalled, rdy;
        logic [31:0] sd;
        logic [4:0]  si;
        c = 0; b = 0; last_hs = -1; stalled = 1'b0; sd = '0; si = '0;
        chk("fetch_no_valid", 32'(outValid), 32'd0);
        while ((b < nb) && (c < 400)) begin
            rdy      = toggle ? (c % 2 == 1) : 1'b1;
            outReady = rdy;
            we       = (c == wr_c);
            waddr    = wa;
            wdata    = wd;
            if (stalled) begin
                chk("stall_valid", 32'(outValid), 32'd1);
                chk("stall_data", outData, sd);
                chk("stall_index", 32'(outIndex), 32'(si));
            end
            stalled = 1'b0;
            if (outValid) begin
                if (rdy) begin
                    chk($sformatf("beat%0d_data", b), outData, exp_d[b]);
                    chk($sformatf("beat%0d_index", b), 32'(outIndex), 32'(exp_i[b]));
                    chk($sformatf("beat%0d_last", b), 32'(outLast), (b == nb - 1) ? 32'd1 : 32'd0);
                    b++;
                    last_hs = c + 1;
                end else begin
                    stalled = 1'b1;
                    sd = outData;
                    si = outIndex;
                end
            end else begin
                chk("no_early_done", 32'(done), 32'd0);
            end
            @(posedge clk); #1;
            c++;
        end
        we = 1'b0;
        outReady = 1'b1;
        chk("beat_count", 32'(b), 32'(nb));
        if (exp_last >= 0) chk("last_hs_edge", 32'(last_hs), 32'(exp_last));
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_in_done", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("done_clear", 32'(done), 32'd0);
        chk("idle_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; outReady = 1'b0; we = 1'b0; rf_rst = 1'b1;
        waddr = '0; wdata = '0; start2 = 1'b0; ready2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(outValid), 32'd0);
        chk("rst_data", outData, 32'd0);
        chk("rst_index", 32'(outIndex), 32'd0);
        chk("rst_last", 32'(outLast), 32'd0);
        chk("rst_addr1", 32'(rdAddr1), 32'd0);
        chk("rst_addr2", 32'(rdAddr2), 32'd1);
        rst = 1'b0;
        rf_rst = 1'b0;
        @(posedge clk); #1;

        // Freshly reset register file, ready high: 0 then 2 x31, checksum 2.
        exp_reset_rf();
        chk("ck_model_reset", exp_d[32], 32'h2);
        kick(1'b0);
        collect(NB, 1'b0, -1, 5'd0, 32'd0, 48 + CK);

        // Load r[i] = i*3 through the negedge write port.
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; waddr = 5'(i); wdata = 32'(i * 3);
            @(posedge clk); #1;
        end
        we = 1'b0;

        // Ready toggling every cycle: order, stability under stall, outLast.
        exp_mul3();
        kick(1'b0);
        collect(NB, 1'b1, -1, 5'd0, 32'd0, -1);

        // Write r5 one cycle after the ptr=4 FETCH (edge 7): old value dumped.
        exp_mul3();
        kick(1'b0);
        collect(NB, 1'b0, 7, 5'd5, 32'hDEAD, 48 + CK);
        exp_d[5] = 32'hDEAD;
        exp_finish();
        kick(1'b0);
        collect(NB, 1'b0, -1, 5'd0, 32'd0, 48 + CK);

        // Reset while in SEND_B of pair 3 (edge 11..12).
        outReady = 1'b1;
        kick(1'b0);
        repeat (11) @(posedge clk);
        #1;
        chk("pre_rst_valid", 32'(outValid), 32'd1);
        chk("pre_rst_index", 32'(outIndex), 32'd7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(outValid), 32'd0);
        chk("abort_addr1", 32'(rdAddr1), 32'd0);
        chk("abort_addr2", 32'(rdAddr2), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("abort_no_done", 32'(done), 32'd0);
        end
        kick(1'b0);
        collect(NB, 1'b0, -1, 5'd0, 32'd0, 48 + CK);

        // start held high: one dump, next FETCH two cycles after done.
        kick(1'b1);
        collect(NB, 1'b0, -1, 5'd0, 32'd0, 48 + CK);
        @(posedge clk); #1;
        chk("restart_fetch_busy", 32'(busy), 32'd1);
        chk("restart_fetch_addr", 32'(rdAddr1), 32'd0);
        start = 1'b0;
        collect(NB, 1'b0, -1, 5'd0, 32'd0, 48 + CK);

        // SIZE=2 instance: r0=0, r1=3.
        ready2 = 1'b1;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        chk("s2_fetch_busy", 32'(busy2), 32'd1);
        chk("s2_fetch_valid", 32'(ov2), 32'd0);
        @(posedge clk); #1;
        chk("s2_b0_data", od2, 32'd0);
        chk("s2_b0_index", 32'(oi2), 32'd0);
        chk("s2_b0_last", 32'(ol2), 32'd0);
        @(posedge clk); #1;
        chk("s2_b1_data", od2, 32'd3);
        chk("s2_b1_index", 32'(oi2), 32'd1);
        chk("s2_b1_last", 32'(ol2), (CK == 1) ? 32'd0 : 32'd1);
        if (CK == 1) begin
            @(posedge clk); #1;
            chk("s2_ck_data", od2, 32'd3);
            chk("s2_ck_index", 32'(oi2), 32'd0);
            chk("s2_ck_last", 32'(ol2), 32'd1);
        end
        @(posedge clk); #1;
        chk("s2_done", 32'(done2), 32'd1);
        @(posedge clk); #1;
        chk("s2_done_clear", 32'(done2), 32'd0);
        chk("s2_idle", 32'(busy2), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
